// File: rtl/cn_job_master_if.sv
// cn_job_master_if
//   Bundles the two buses that cn_job_master sits between:
//     - the host job stream: job_valid / job_ready / job_data
//     - the miner core register port: reg_address / reg_write / reg_wrdata / reg_rddata
//   Modports:
//     master : the job master's view. It consumes job words and initiates register accesses.
//     slave  : the opposite side, meaning the job source together with the register responder.
interface cn_job_master_if;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_data;
  logic [9:0]  reg_address;
  logic        reg_write;
  logic [31:0] reg_wrdata;
  logic [31:0] reg_rddata;

  modport master (
    input  job_valid, job_data, reg_rddata,
    output job_ready, reg_address, reg_write, reg_wrdata
  );

  modport slave (
    output job_valid, job_data, reg_rddata,
    input  job_ready, reg_address, reg_write, reg_wrdata
  );
endinterface

// File: rtl/cn_job_master.sv
// cn_job_master
//   Register-bus initiator for the miner core. For each job it performs these steps in order:
//     1. Clear the sticky finish flag.
//     2. Stream H0_WORDS h0 words to 0x100+k, then CODE_WORDS code words to 0x000+k.
//     3. Write the start bit.
//     4. Poll status until bit0 is set.
//     5. Acknowledge the finish.
//     6. Pulse done and report the elapsed cycle count.
//   If the core does not finish within TIMEOUT_CYCLES, the block writes the soft-reset
//   register instead and pulses timeout_err.
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   bus          job stream and register port (cn_job_master_if.master)
//   busy         high from leaving IDLE until returning to IDLE
//   done         one-cycle pulse after a successful job
//   timeout_err  one-cycle pulse together with the soft-reset write
//   run_cycles   cycles from the start write to the finishing status sample
module cn_job_master #(
  parameter int          H0_WORDS       = 28,
  parameter int          CODE_WORDS     = 142,
  parameter int          POLL_INTERVAL  = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h0100_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  cn_job_master_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic [31:0]            run_cycles
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CLR       = 4'd1;
  localparam logic [3:0] S_LOAD_H0   = 4'd2;
  localparam logic [3:0] S_LOAD_CODE = 4'd3;
  localparam logic [3:0] S_START     = 4'd4;
  localparam logic [3:0] S_POLL_WAIT = 4'd5;
  localparam logic [3:0] S_RD_ADDR   = 4'd6;
  localparam logic [3:0] S_RD_SAMPLE = 4'd7;
  localparam logic [3:0] S_ACK       = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;
  localparam logic [3:0] S_SRST      = 4'd10;

  localparam logic [9:0] ADDR_STATUS  = 10'h200;
  localparam logic [9:0] ADDR_CLEAR   = 10'h201;
  localparam logic [9:0] ADDR_SOFTRST = 10'h202;
  localparam logic [9:0] ADDR_H0_BASE = 10'h100;

  localparam logic [8:0]  H0_LAST      = 9'(H0_WORDS - 1);
  localparam logic [8:0]  CODE_LAST    = 9'(CODE_WORDS - 1);
  localparam logic [15:0] POLL_LAST    = 16'(POLL_INTERVAL - 1);
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 32'd1;

  logic [3:0]  state_reg, state_next;
  logic [8:0]  word_cnt_reg;
  logic [15:0] poll_cnt_reg;
  logic [31:0] cyc_cnt_reg;
  logic        job_ready_reg;
  logic        busy_reg;
  logic        done_reg;
  logic        timeout_err_reg;
  logic [31:0] run_cycles_reg;
  logic [9:0]  reg_address_reg;
  logic        reg_write_reg;
  logic [31:0] reg_wrdata_reg;

  logic accept;
  logic finish;
  logic expired;
  logic polling;

  assign accept  = bus.job_valid && job_ready_reg;
  assign finish  = bus.reg_rddata[0];
  // One counter serves both purposes: it is the elapsed run time and the watchdog.
  // Comparing against TIMEOUT_CYCLES-1 makes the TIMEOUT_CYCLES-th polling cycle the last one.
  assign expired = (cyc_cnt_reg >= TIMEOUT_LAST);
  assign polling = (state_reg == S_POLL_WAIT) || (state_reg == S_RD_ADDR) ||
                   (state_reg == S_RD_SAMPLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (bus.job_valid) state_next = S_CLR;
      S_CLR:       state_next = S_LOAD_H0;
      S_LOAD_H0:   if (accept && (word_cnt_reg == H0_LAST)) state_next = S_LOAD_CODE;
      S_LOAD_CODE: if (accept && (word_cnt_reg == CODE_LAST)) state_next = S_START;
      S_START:     state_next = S_POLL_WAIT;
      S_POLL_WAIT: begin
        if (expired)                        state_next = S_SRST;
        else if (poll_cnt_reg == POLL_LAST) state_next = S_RD_ADDR;
      end
      S_RD_ADDR:   state_next = expired ? S_SRST : S_RD_SAMPLE;
      // A finish seen on the expiry cycle still completes the job normally.
      S_RD_SAMPLE: begin
        if (finish)       state_next = S_ACK;
        else if (expired) state_next = S_SRST;
        else              state_next = S_POLL_WAIT;
      end
      S_ACK:       state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      S_SRST:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      word_cnt_reg    <= '0;
      poll_cnt_reg    <= '0;
      cyc_cnt_reg     <= '0;
      job_ready_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      timeout_err_reg <= 1'b0;
      run_cycles_reg  <= '0;
      reg_address_reg <= '0;
      reg_write_reg   <= 1'b0;
      reg_wrdata_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      busy_reg        <= (state_next != S_IDLE);
      // job_ready is derived from the next state, so it is already high in the
      // first load cycle and already low in the START cycle.
      job_ready_reg   <= (state_next == S_LOAD_H0) || (state_next == S_LOAD_CODE);
      done_reg        <= (state_reg == S_DONE);
      timeout_err_reg <= (state_reg == S_SRST);
      reg_write_reg   <= 1'b0;
      reg_wrdata_reg  <= '0;
      poll_cnt_reg    <= (state_reg == S_POLL_WAIT) ? poll_cnt_reg + 16'd1 : 16'd0;

      if (polling && (cyc_cnt_reg != 32'hFFFF_FFFF)) cyc_cnt_reg <= cyc_cnt_reg + 32'd1;

      // Each write is issued from its state and appears on the bus in the
      // following cycle. This lets the start write follow the last code write
      // without the two colliding.
      case (state_reg)
        S_CLR: begin
          reg_write_reg   <= 1'b1;
          reg_address_reg <= ADDR_CLEAR;
          word_cnt_reg    <= '0;
        end
        S_LOAD_H0: if (accept) begin
          reg_write_reg   <= 1'b1;
          reg_address_reg <= ADDR_H0_BASE + {1'b0, word_cnt_reg};
          reg_wrdata_reg  <= bus.job_data;
          word_cnt_reg    <= (word_cnt_reg == H0_LAST) ? 9'd0 : word_cnt_reg + 9'd1;
        end
        S_LOAD_CODE: if (accept) begin
          reg_write_reg   <= 1'b1;
          reg_address_reg <= {1'b0, word_cnt_reg};
          reg_wrdata_reg  <= bus.job_data;
          word_cnt_reg    <= (word_cnt_reg == CODE_LAST) ? 9'd0 : word_cnt_reg + 9'd1;
        end
        S_START: begin
          reg_write_reg   <= 1'b1;
          reg_address_reg <= ADDR_STATUS;
          reg_wrdata_reg  <= 32'd1;
          cyc_cnt_reg     <= '0;
        end
        S_POLL_WAIT: if (state_next == S_RD_ADDR) reg_address_reg <= ADDR_STATUS;
        S_RD_SAMPLE: if (finish) run_cycles_reg <= cyc_cnt_reg;
        S_ACK: begin
          reg_write_reg   <= 1'b1;
          reg_address_reg <= ADDR_CLEAR;
        end
        S_SRST: begin
          reg_write_reg   <= 1'b1;
          reg_address_reg <= ADDR_SOFTRST;
        end
        default: ;
      endcase
    end
  end

  assign bus.job_ready   = job_ready_reg;
  assign bus.reg_address = reg_address_reg;
  assign bus.reg_write   = reg_write_reg;
  assign bus.reg_wrdata  = reg_wrdata_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign timeout_err     = timeout_err_reg;
  assign run_cycles      = run_cycles_reg;

endmodule

// File: doc/cn_job_master.md
Name: cn_job_master

Overview:
- Register-bus initiator that drives the miner core's 10-bit register port.
- Per job, in order: clears the sticky finish flag, writes h0 and the random-program code words, writes the start bit, polls status until finish, acknowledges, reports done and the elapsed cycle count.
- A watchdog issues a soft-reset write if the core never finishes.
- Sits between the host job stream and the core's register port; the memory port is not driven.

Parameters:
- H0_WORDS, 28, number of 32-bit h0 words per job, written to 0x100+k.
- CODE_WORDS, 142, number of 32-bit code words per job, written to 0x000+k (low half of each 64-bit op first).
- POLL_INTERVAL, 16, idle cycles between status reads (minimum 1).
- TIMEOUT_CYCLES, 32'h0100_0000, cycles from the start write to soft reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- job_valid  in  1  job word available.
- job_ready  out  1  job word accepted when job_valid && job_ready.
- job_data  in  32  job word: H0_WORDS h0 words, then CODE_WORDS code words.
- busy  out  1  high from leaving IDLE until returning to IDLE.
- done  out  1  one-cycle pulse on successful completion.
- timeout_err  out  1  one-cycle pulse after the soft-reset write.
- run_cycles  out  32  cycles from start write to finish sample; held until the next start.
- reg_address  out  10  register address.
- reg_write  out  1  write strobe, one cycle per write.
- reg_wrdata  out  32  write data.
- reg_rddata  in  32  responder read data, registered one cycle after reg_address.

Behaviour:
- All outputs registered. Reset values: every output 0; state IDLE.
- Reset mid-job aborts without any further write. A partially loaded job is discarded and upstream must resend it whole.
- Fixed addresses: STATUS/START 0x200, CLEAR 0x201, SOFTRST 0x202.

States and transitions:
- IDLE: job_ready=0. On job_valid (no word consumed) -> CLR.
- CLR: one write 0x201 <- 0, clearing any stale finish flag. Next -> LOAD_H0.
- LOAD_H0: job_ready=1. Each accepted word produces, in the next cycle, a single-cycle write to 0x100+k, k=0..H0_WORDS-1.
  - When job_valid is low: no write, hold k, no timeout.
  - After the last word -> LOAD_CODE.
- LOAD_CODE: same rules, address k for k=0..CODE_WORDS-1 (max 256). After the last word -> START.
- START: job_ready=0. Write 0x200 <- 1; clear the run counter and timeout counter. Next -> POLL_WAIT.
- POLL_WAIT: count POLL_INTERVAL cycles -> RD_ADDR.
- RD_ADDR: drive reg_address=0x200, reg_write=0. Next -> RD_SAMPLE.
- RD_SAMPLE: address held; sample reg_rddata.
  - bit0=1: latch run_cycles -> ACK.
  - Otherwise -> POLL_WAIT.
- ACK: write 0x201 <- 0. Next -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Timeout: the counter runs from START through POLL_WAIT/RD_*. When it reaches TIMEOUT_CYCLES in any polling state -> SRST.
  - If finish is sampled in the same cycle as expiry, finish wins.
- SRST: write 0x202 <- 0, timeout_err=1 for one cycle -> IDLE. run_cycles is not updated.

Arithmetic and timing rules:
- run_cycles counts clk edges after the START write cycle, up to and including the RD_SAMPLE cycle that sees finish. It saturates at 32'hFFFF_FFFF.
- Throughput: with job_valid held high, one register write per cycle during load. Full default job = 1 + 170 + 1 write cycles before polling.
- reg_wrdata is don't-care but held at 0 when reg_write=0. reg_address holds its last value outside write and read cycles.
- job_valid arriving while busy is not consumed until the next LOAD_H0.

Test Plan:
- Default params; responder model sets status bit0 100 cycles after start; job stream continuous with values 0x1000+i.
  - Writes in order: 0x201<-0; 0x100..0x11B <- 0x1000..0x101B; 0x000..0x08D <- 0x101C..0x10A9; 0x200<-1.
  - Then polls on 16-cycle spacing, ACK writes 0x201<-0, done pulses once, run_cycles within [100,100+POLL_INTERVAL+2].
- Stalled stream: job_valid toggles 1/0 every cycle during load. Same address/data sequence, no duplicate or skipped writes, job_ready never accepts more than 170 words.
- Stale finish: responder bit0=1 at job start. The CLR write clears it before the start write, and the first poll after start must not complete if the model has not yet finished.
- Timeout: TIMEOUT_CYCLES=500, responder never finishes. Exactly one write 0x202<-0, timeout_err pulse, done stays 0, busy falls, run_cycles unchanged.
- Reset asserted after 50 code words. All outputs 0 the next cycle, no further writes. The next job restarts with the CLR write and h0 address 0x100.
- Finish and timeout coincide: TIMEOUT_CYCLES tuned so the finish sample lands on the expiry cycle. The ACK path is taken, done=1, and no 0x202 write occurs.
